// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall/sequencing controller with MUL/DIV latency FSM
//
// Drives the 6-bit StallBus (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = Stop)
// from two sources: the single-cycle ID load-use request and the multi-cycle
// MUL/DIV unit in EX, which is sequenced by an internal FSM and latency counter.
//
// Optional feature: define STALL_CTRL_PERF_EN to build the saturating 32-bit
// EX/ID stall-cycle counters; otherwise both counter outputs are tied to zero.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            asynchronous active-high reset
//   flush_i          pipeline flush; aborts any MUL/DIV sequence
//   stallreq_id_i    load-use hazard request from ID (same cycle)
//   md_mul_start_i   EX holds a MUL/MULT(U) this cycle
//   md_div_start_i   EX holds a DIV(U) this cycle
//   stall_o          StallBus
//   md_busy_o        MUL/DIV sequence in progress
//   md_ready_o       one-cycle pulse, MUL/DIV result valid
//   stall_cyc_ex_o   EX-stall cycle count
//   stall_cyc_id_o   ID-stall cycle count
module stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        stallreq_id_i,
  input  logic        md_mul_start_i,
  input  logic        md_div_start_i,
  output logic [5:0]  stall_o,
  output logic        md_busy_o,
  output logic        md_ready_o,
  output logic [31:0] stall_cyc_ex_o,
  output logic [31:0] stall_cyc_id_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_DIV_BUSY,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             md_ready_q;

  logic busy;
  logic accept;
  logic start_any;
  logic stall_ex;

  assign busy      = (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);
  assign accept    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_any = md_mul_start_i || md_div_start_i;
  assign stall_ex  = (accept && start_any) || busy;

  // The counter holds the number of busy cycles still to run, the current one
  // included. An op of latency L spends one start cycle plus L-2 busy cycles
  // before DONE, so the last busy cycle is the one that sees a count of 1.
  // A latency of 2 has no busy cycles and goes straight to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      md_ready_q <= 1'b0;
    end else if (flush_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      md_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          md_ready_q <= 1'b0;
          if (md_div_start_i) begin
            if (DIV_LOAD == '0) begin
              state_q    <= S_DONE;
              md_ready_q <= 1'b1;
            end else begin
              state_q <= S_DIV_BUSY;
              cnt_q   <= DIV_LOAD;
            end
          end else if (md_mul_start_i) begin
            if (MUL_LOAD == '0) begin
              state_q    <= S_DONE;
              md_ready_q <= 1'b1;
            end else begin
              state_q <= S_MUL_BUSY;
              cnt_q   <= MUL_LOAD;
            end
          end
        end
        S_MUL_BUSY, S_DIV_BUSY: begin
          if (cnt_q <= CNT_ONE) begin
            state_q    <= S_DONE;
            cnt_q      <= '0;
            md_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          md_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing on the DONE cycle cancels the result pulse.
  assign md_ready_o = md_ready_q && !flush_i;
  assign md_busy_o  = !rst_i && (busy || stall_ex);

  always_comb begin
    stall_o = 6'b000000;
    if (rst_i || flush_i) begin
      stall_o = 6'b000000;
    end else if (stall_ex) begin
      stall_o = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_o = 6'b000111;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] cyc_ex_q;
  logic [31:0] cyc_id_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_ex_q <= '0;
      cyc_id_q <= '0;
    end else begin
      if ((stall_o == 6'b001111) && (cyc_ex_q != 32'hFFFF_FFFF)) begin
        cyc_ex_q <= cyc_ex_q + 32'd1;
      end
      if ((stall_o == 6'b000111) && (cyc_id_q != 32'hFFFF_FFFF)) begin
        cyc_id_q <= cyc_id_q + 32'd1;
      end
    end
  end

  assign stall_cyc_ex_o = cyc_ex_q;
  assign stall_cyc_id_o = cyc_id_q;
`else
  assign stall_cyc_ex_o = 32'h0;
  assign stall_cyc_id_o = 32'h0;
`endif

endmodule
